// File: rtl/calc_vga_pkg.sv
// Shared types, sizes and default colours for the calculator VGA cursor/pixel block.
package calc_vga_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 6;

   typedef logic [1:0]  col_t;
   typedef logic [2:0]  row_t;
   typedef logic [4:0]  key_code_t;
   typedef logic [11:0] rgb_t;

   localparam rgb_t DEF_BG_COLOR     = 12'h000;
   localparam rgb_t DEF_CELL_COLOR   = 12'h333;
   localparam rgb_t DEF_LINE_COLOR   = 12'hFFF;
   localparam rgb_t DEF_CURSOR_COLOR = 12'h0F0;

   // Bit positions of the buttons inside the packed button vector.
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_OK    = 4;
   localparam int NUM_BTNS  = 5;

   // With four columns, row*4 + col is simply the concatenation {row, col}.
   function automatic key_code_t key_code_f(input row_t y, input col_t x);
      return {y, x};
   endfunction

endpackage

// File: rtl/calc_cursor_pixel_if.sv
// Key event handshake from the cursor block to the calculator logic.
interface calc_cursor_pixel_if;
   import calc_vga_pkg::*;

   logic      key_valid;
   key_code_t key_code;
   logic      key_ready;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/btn_frame_sampler.sv
// Synchronizes raw buttons and samples them once per frame; emits a one-cycle
// press pulse on the frame_start cycle for buttons that went from released to held.
module btn_frame_sampler
   import calc_vga_pkg::*;
#(
   parameter int N = NUM_BTNS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_frame_start,
   input  logic [N-1:0] i_btn,
   output logic [N-1:0] o_press
);

   logic [N-1:0] r_sync1;
   logic [N-1:0] r_sync2;
   logic [N-1:0] r_samp;

   // Two-flop synchronizer, running every clock.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Frame latch: r_samp keeps the sample from the previous frame_start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_samp <= '0;
      end else if (i_frame_start) begin
         r_samp <= r_sync2;
      end
   end

   // On frame_start r_sync2 is this frame's sample and r_samp the previous one.
   assign o_press = i_frame_start ? (r_sync2 & ~r_samp) : '0;

endmodule

// File: rtl/calc_cursor_pixel.sv
// Cursor over the 4x6 key matrix, key event handshake, and the registered pixel
// colour mux layered over the calculator grid template.
module calc_cursor_pixel
   import calc_vga_pkg::*;
#(
   parameter int   GRID_XI      = 312,
   parameter int   GRID_XF      = 712,
   parameter int   GRID_YI      = 84,
   parameter int   GRID_YF      = 684,
   parameter int   H_VISIBLE    = 1024,
   parameter int   V_VISIBLE    = 768,
   parameter int   BLINK_FRAMES = 30,
   parameter rgb_t BG_COLOR     = DEF_BG_COLOR,
   parameter rgb_t CELL_COLOR   = DEF_CELL_COLOR,
   parameter rgb_t LINE_COLOR   = DEF_LINE_COLOR,
   parameter rgb_t CURSOR_COLOR = DEF_CURSOR_COLOR
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [11:0]                hc,
   input  logic [11:0]                vc,
   input  col_t                       matrix_x,
   input  row_t                       matrix_y,
   input  logic                       lines,
   input  logic                       btn_up,
   input  logic                       btn_down,
   input  logic                       btn_left,
   input  logic                       btn_right,
   input  logic                       btn_ok,
   calc_cursor_pixel_if.master        key_if,
   output col_t                       cur_x,
   output row_t                       cur_y,
   output rgb_t                       rgb
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic                w_frame_start;
   logic [NUM_BTNS-1:0] w_btn;
   logic [NUM_BTNS-1:0] w_press;
   logic                w_up, w_dn, w_lf, w_rt, w_move;
   col_t                w_cur_x_nxt;
   row_t                w_cur_y_nxt;

   col_t                r_cur_x;
   row_t                r_cur_y;
   logic [CNT_W-1:0]    r_frame_cnt;
   logic                r_blink;
   logic                r_key_valid;
   key_code_t           r_key_code;

   logic [11:0]         r_hc_d;
   logic [11:0]         r_vc_d;
   logic                w_vis;
   logic                w_in_grid;
   logic                w_cursor_hit;
   rgb_t                w_rgb_nxt;
   rgb_t                r_rgb;

   assign w_frame_start = (hc == 12'd0) && (vc == 12'd0);

   assign w_btn[BTN_UP]    = btn_up;
   assign w_btn[BTN_DOWN]  = btn_down;
   assign w_btn[BTN_LEFT]  = btn_left;
   assign w_btn[BTN_RIGHT] = btn_right;
   assign w_btn[BTN_OK]    = btn_ok;

   btn_frame_sampler #(.N(NUM_BTNS)) u_sampler (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_frame_start (w_frame_start),
      .i_btn         (w_btn),
      .o_press       (w_press)
   );

   // Opposing presses in the same frame cancel each other out.
   assign w_up   = w_press[BTN_UP]    & ~w_press[BTN_DOWN];
   assign w_dn   = w_press[BTN_DOWN]  & ~w_press[BTN_UP];
   assign w_lf   = w_press[BTN_LEFT]  & ~w_press[BTN_RIGHT];
   assign w_rt   = w_press[BTN_RIGHT] & ~w_press[BTN_LEFT];
   assign w_move = w_up | w_dn | w_lf | w_rt;

   // Next cursor position with wrap-around on both axes.
   always_comb begin
      w_cur_x_nxt = r_cur_x;
      w_cur_y_nxt = r_cur_y;
      if (w_up)
         w_cur_y_nxt = (r_cur_y == 3'd0) ? row_t'(NUM_ROWS - 1) : r_cur_y - 3'd1;
      else if (w_dn)
         w_cur_y_nxt = (r_cur_y == row_t'(NUM_ROWS - 1)) ? 3'd0 : r_cur_y + 3'd1;
      if (w_lf)
         w_cur_x_nxt = (r_cur_x == 2'd0) ? col_t'(NUM_COLS - 1) : r_cur_x - 2'd1;
      else if (w_rt)
         w_cur_x_nxt = (r_cur_x == col_t'(NUM_COLS - 1)) ? 2'd0 : r_cur_x + 2'd1;
   end

   // Cursor position register; presses only exist on frame_start cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cur_x <= '0;
         r_cur_y <= '0;
      end else begin
         r_cur_x <= w_cur_x_nxt;
         r_cur_y <= w_cur_y_nxt;
      end
   end

   // Blink timer: a move restarts the on phase so the new cell shows at once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (w_move) begin
         r_frame_cnt <= '0;
         r_blink     <= 1'b1;
      end else if (w_frame_start) begin
         if (r_frame_cnt == CNT_LAST) begin
            r_frame_cnt <= '0;
            r_blink     <= ~r_blink;
         end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
         end
      end
   end

   // Single-entry key event: ok presses while one is pending are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
      end else if (r_key_valid && key_if.key_ready) begin
         r_key_valid <= 1'b0;
      end else if (w_press[BTN_OK] && !r_key_valid) begin
         r_key_valid <= 1'b1;
         r_key_code  <= key_code_f(r_cur_y, r_cur_x);
      end
   end

   assign key_if.key_valid = r_key_valid;
   assign key_if.key_code  = r_key_code;
   assign cur_x            = r_cur_x;
   assign cur_y            = r_cur_y;

   // Stage 1: delay the raster counters to line up with the template's matrix outputs.
   always_ff @(posedge clk) begin
      r_hc_d <= hc;
      r_vc_d <= vc;
   end

   assign w_vis        = (r_hc_d < 12'(H_VISIBLE)) && (r_vc_d < 12'(V_VISIBLE));
   assign w_in_grid    = (r_hc_d > 12'(GRID_XI)) && (r_hc_d <= 12'(GRID_XF)) &&
                         (r_vc_d > 12'(GRID_YI)) && (r_vc_d <= 12'(GRID_YF));
   assign w_cursor_hit = (matrix_x == r_cur_x) && (matrix_y == r_cur_y);

   // Colour priority: blanking, grid lines, blinking cursor, cell, background.
   always_comb begin
      w_rgb_nxt = BG_COLOR;
      if (!w_vis)
         w_rgb_nxt = 12'h000;
      else if (w_in_grid && lines)
         w_rgb_nxt = LINE_COLOR;
      else if (w_in_grid && w_cursor_hit && r_blink)
         w_rgb_nxt = CURSOR_COLOR;
      else if (w_in_grid)
         w_rgb_nxt = CELL_COLOR;
   end

   // Stage 2: registered pixel output.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_rgb <= '0;
      else
         r_rgb <= w_rgb_nxt;
   end

   assign rgb = r_rgb;

endmodule

// File: tb/tb_calc_cursor_pixel.sv
// Directed bench for calc_cursor_pixel: cursor moves and wrap, key handshake,
// pixel priority, blink timing and mid-operation reset.
module tb_calc_cursor_pixel;
   import calc_vga_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] hc, vc;
   col_t        matrix_x;
   row_t        matrix_y;
   logic        lines;
   logic [4:0]  btn;          // {ok, right, left, down, up}
   col_t        cur_x;
   row_t        cur_y;
   rgb_t        rgb;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LF = 5'b00100,
                          M_RT = 5'b01000, M_OK = 5'b10000;

   calc_cursor_pixel_if key_if ();

   calc_cursor_pixel #(.BLINK_FRAMES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .hc        (hc),
      .vc        (vc),
      .matrix_x  (matrix_x),
      .matrix_y  (matrix_y),
      .lines     (lines),
      .btn_up    (btn[0]),
      .btn_down  (btn[1]),
      .btn_left  (btn[2]),
      .btn_right (btn[3]),
      .btn_ok    (btn[4]),
      .key_if    (key_if),
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .rgb       (rgb)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_fs();
      hc = 12'd0; vc = 12'd0;
      tick(1);
      hc = 12'd2000; vc = 12'd2000;
   endtask

   // Press for one frame, then release for one frame.
   task automatic press_btn(input logic [4:0] m);
      btn = m;  tick(3); do_fs();
      btn = '0; tick(3); do_fs();
   endtask

   task automatic pix(input string tag, input int h, input int v, input int mx,
                      input int my, input logic ln, input rgb_t exp);
      hc = 12'(h); vc = 12'(v);
      matrix_x = col_t'(mx); matrix_y = row_t'(my); lines = ln;
      tick(2);
      check(tag, 32'(rgb), 32'(exp));
      hc = 12'd2000; vc = 12'd2000; lines = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; hc = 12'd2000; vc = 12'd2000;
      matrix_x = '0; matrix_y = '0; lines = 1'b0; btn = '0;
      key_if.key_ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
      check("rst_cur_x", 32'(cur_x), 0);
      check("rst_cur_y", 32'(cur_y), 0);
      check("rst_kv", 32'(key_if.key_valid), 0);
      check("rst_rgb", 32'(rgb), 0);

      // Left held across three frame_starts: one move only.
      btn = M_LF; tick(3);
      do_fs(); check("left_wrap_1", 32'(cur_x), 3);
      tick(3); do_fs(); check("left_held_2", 32'(cur_x), 3);
      tick(3); do_fs(); check("left_held_3", 32'(cur_x), 3);
      btn = '0; tick(3); do_fs();
      press_btn(M_LF); check("left_repress", 32'(cur_x), 2);
      press_btn(M_UP); check("up_wrap", 32'(cur_y), 5);

      // Walk to (1,2) and press up+down+right together.
      press_btn(M_LF); press_btn(M_DN); press_btn(M_DN); press_btn(M_DN);
      check("walk_x", 32'(cur_x), 1);
      check("walk_y", 32'(cur_y), 2);
      press_btn(M_UP | M_DN | M_RT);
      check("simul_x", 32'(cur_x), 2);
      check("simul_y", 32'(cur_y), 2);

      // Move to (3,5) and raise a key event.
      press_btn(M_RT); press_btn(M_UP); press_btn(M_UP); press_btn(M_UP);
      check("pos35", 32'({cur_y, cur_x}), 32'({3'd5, 2'd3}));
      press_btn(M_OK);
      check("key_set", 32'({key_if.key_valid, key_if.key_code}), 32'({1'b1, 5'd23}));
      for (int i = 0; i < 100; i++) begin
         tick(1);
         check("key_hold", 32'({key_if.key_valid, key_if.key_code}), 32'({1'b1, 5'd23}));
      end
      press_btn(M_LF);
      check("key_hold_move", 32'({key_if.key_valid, key_if.key_code}), 32'({1'b1, 5'd23}));
      press_btn(M_OK);
      check("key_drop", 32'({key_if.key_valid, key_if.key_code}), 32'({1'b1, 5'd23}));

      // Acceptance on the same cycle as another ok press: event clears, press dropped.
      btn = M_OK; tick(3);
      key_if.key_ready = 1'b1; hc = 12'd0; vc = 12'd0;
      tick(1);
      hc = 12'd2000; vc = 12'd2000; key_if.key_ready = 1'b0;
      check("key_accept", 32'(key_if.key_valid), 0);
      tick(2);
      check("key_stays_clear", 32'(key_if.key_valid), 0);
      btn = '0; tick(3); do_fs();
      press_btn(M_OK);
      check("key_new_code", 32'({key_if.key_valid, key_if.key_code}), 32'({1'b1, 5'd22}));

      // Reset mid-frame with a pending key event.
      hc = 12'd500; vc = 12'd300;
      rst_n = 1'b0; tick(2); rst_n = 1'b1;
      check("mid_rst_cur", 32'({cur_y, cur_x}), 0);
      check("mid_rst_kv", 32'(key_if.key_valid), 0);
      check("mid_rst_rgb", 32'(rgb), 0);
      hc = 12'd2000; vc = 12'd2000;
      do_fs();
      pix("mid_rst_cursor", 400, 200, 0, 0, 1'b0, 12'h0F0);

      // Pixel priority and grid boundaries.
      pix("line_xf", 712, 200, 0, 0, 1'b1, 12'hFFF);
      pix("cursor_cell", 400, 200, 0, 0, 1'b0, 12'h0F0);
      pix("bg_left", 100, 200, 0, 0, 1'b0, 12'h000);
      pix("blank_h", 1100, 200, 0, 0, 1'b0, 12'h000);
      pix("bg_xi_edge", 312, 200, 0, 0, 1'b1, 12'h000);
      pix("bg_yi_edge", 400, 84, 0, 0, 1'b1, 12'h000);
      pix("line_yf", 400, 684, 0, 0, 1'b1, 12'hFFF);
      pix("cell_other", 400, 200, 1, 0, 1'b0, 12'h333);
      pix("cell_row6", 400, 200, 0, 6, 1'b0, 12'h333);
      pix("cell_row7", 400, 200, 0, 7, 1'b0, 12'h333);

      // Blink with two frames per half-period.
      do_fs(); pix("blink_off_1", 400, 200, 0, 0, 1'b0, 12'h333);
      do_fs(); pix("blink_off_2", 400, 200, 0, 0, 1'b0, 12'h333);
      do_fs(); pix("blink_on_1", 400, 200, 0, 0, 1'b0, 12'h0F0);
      do_fs(); pix("blink_on_2", 400, 200, 0, 0, 1'b0, 12'h0F0);
      do_fs(); pix("blink_off_3", 400, 200, 0, 0, 1'b0, 12'h333);
      btn = M_RT; tick(3); do_fs();
      check("move_x", 32'(cur_x), 1);
      pix("move_forces_on", 400, 200, 1, 0, 1'b0, 12'h0F0);
      btn = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/calc_cursor_pixel.md
Name: calc_cursor_pixel

Overview:
- Downstream consumer of the calculator grid template.
- Takes the raster counters (hc, vc) and the template's cell coordinates (matrix_x, matrix_y) and line flag (lines).
- Keeps a cursor over the 4x6 key matrix, driven by push buttons sampled once per frame.
- Emits one registered 12-bit RGB pixel per clock, plus a valid/ready key event carrying the selected key code to the calculator logic.

Parameters:
- GRID_XI, 312, left grid edge; must match the template instance.
- GRID_XF, 712, right grid edge; must match the template instance.
- GRID_YI, 84, top grid edge; must match the template instance.
- GRID_YF, 684, bottom grid edge; must match the template instance.
- H_VISIBLE, 1024, visible pixels per line.
- V_VISIBLE, 768, visible lines per frame.
- BLINK_FRAMES, 30, frames per cursor blink half-period (minimum 1).
- BG_COLOR, 12'h000, pixel colour inside the visible area but outside the grid.
- CELL_COLOR, 12'h333, cell interior colour.
- LINE_COLOR, 12'hFFF, grid line colour.
- CURSOR_COLOR, 12'h0F0, colour of the cursor cell interior while the blink phase is on.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- hc  in  12  horizontal raster counter.
- vc  in  12  vertical raster counter.
- matrix_x  in  2  template column index, 0..3.
- matrix_y  in  3  template row index, 0..5.
- lines  in  1  template grid-line flag.
- btn_up, btn_down, btn_left, btn_right, btn_ok  in  1 each  raw asynchronous buttons, active-high.
- key_ready  in  1  consumer accepts the key event.
- key_valid  out  1  key event pending.
- key_code  out  5  selected key, equal to cur_y*4 + cur_x (0..23).
- cur_x  out  2  cursor column.
- cur_y  out  3  cursor row.
- rgb  out  12  pixel colour {R4,G4,B4}.

Behaviour:
- Reset: all state is synchronous to clk; rst_n=0 at any edge applies the following, including mid-frame and with a pending key.
  - Cleared to 0: cur_x, cur_y, key_valid, key_code, rgb, sampled and previous button registers, frame counter.
  - blink phase is set to on (1).
- Button path: each button goes through a 2-FF synchronizer every clock.
- frame_start: asserted for one cycle when hc==0 and vc==0.
  - On frame_start, each synchronized button is latched into samp.
  - press = samp & ~samp_prev, evaluated on the same frame_start cycle.
  - Frame-rate sampling is the debounce; at most one move per frame.
- Cursor moves on the frame_start cycle:
  - up: cur_y-1, wraps 0 to 5.
  - down: cur_y+1, wraps 5 to 0.
  - left: cur_x-1, wraps 0 to 3.
  - right: cur_x+1, wraps 3 to 0.
  - up and down pressed together: no vertical move. left and right together: no horizontal move.
  - A vertical move and a horizontal move in the same frame both apply.
- Key handshake:
  - An ok press with key_valid=0 sets key_valid=1 and key_code = {cursor before this frame's move}.
  - key_valid and key_code hold until a cycle with key_valid & key_ready; key_valid clears on the following edge.
  - An ok press while key_valid=1 is dropped, including on the cycle where key_ready=1. There is no queue.
  - key_code is stable whenever key_valid=1.
- Blink:
  - The frame counter increments on each frame_start.
  - At BLINK_FRAMES-1 the counter returns to 0 and the blink phase toggles.
  - Any cursor move forces the blink phase on and clears the counter.
- Pixel path, stage 1:
  - hc and vc are registered once to align with the template's registered matrix outputs.
  - From the delayed values derive vis = (hc_d < H_VISIBLE) & (vc_d < V_VISIBLE).
  - Also derive in_grid = (GRID_XI < hc_d <= GRID_XF) & (GRID_YI < vc_d <= GRID_YF).
- Pixel path, stage 2: rgb is registered; priority is first match in this order:
  - !vis gives 0.
  - in_grid & lines gives LINE_COLOR.
  - in_grid & matrix==cursor & blink gives CURSOR_COLOR.
  - in_grid gives CELL_COLOR.
  - Otherwise BG_COLOR.
- Latency: rgb is 2 clocks after hc/vc and 1 clock after matrix_x, matrix_y and lines.
- Out-of-range inputs: matrix_y values 6 and 7 never match the cursor and render CELL_COLOR.

Decomposition:
- Package calc_vga_pkg holds:
  - NUM_COLS=4, NUM_ROWS=6.
  - Typedefs col_t (2b), row_t (3b), key_code_t (5b), rgb_t (12b).
  - Default colour constants.
- Sub-module btn_frame_sampler: 2-FF synchronizer, frame latch and rising-edge press output.
  - Instantiated with a 5-bit vector for all five buttons.
- The cursor/handshake logic and the pixel mux stay in calc_cursor_pixel.

Test Plan:
- Reset mid-operation:
  - Stimulus: rst_n=0 for 2 clocks, asserted mid-frame with key_valid=1.
  - Required response: cur=(0,0), key_valid=0, rgb=0, and after one frame the cursor cell renders 12'h0F0.
- Cursor moves and wrap:
  - Stimulus: hold btn_left across 3 frame_starts.
  - Required response: cur_x goes 0 to 3 exactly once; releasing and re-pressing gives 2. btn_up from y=0 gives y=5.
- Simultaneous presses:
  - Stimulus: up+down+right pressed in the same frame from (1,2).
  - Required response: cursor becomes (2,2).
- Key handshake:
  - Stimulus: move to (3,5), press ok, hold key_ready=0 for 100 clocks; press ok again in a later frame; then key_ready=1.
  - Required response: key_valid=1 with code 23 throughout; the second press is dropped; key_valid=0 one clock after acceptance.
- Pixel priority:
  - Stimulus: hc=GRID_XF with lines=1, then a pixel inside the cursor cell, then hc=100, then hc=1100.
  - Required response: rgb is 12'hFFF, 12'h0F0, 12'h000 (BG_COLOR), then 0 respectively, each 2 clocks after the hc/vc stimulus.
- Blink:
  - Stimulus: BLINK_FRAMES=2, no buttons pressed.
  - Required response: the cursor cell alternates between 12'h0F0 and 12'h333 every 2 frames; a move forces 12'h0F0 immediately.
